// File: rtl/uarc_interrupt_ctrl.sv
// Vectored interrupt controller: per-bus enable/selection masking, fixed lowest-index priority,
// handler address table, WAIT wake-up and a one-cycle acknowledge handshake toward the receivers.
module uarc_interrupt_ctrl #(
  parameter int WORD_MAG           = 5,
  parameter int UARC_SETS          = 1,
  parameter int TOTAL_BUSES        = 4,
  parameter int PROGRAM_ADDR_WIDTH = 8,
  localparam int WORD_WIDTH        = 1 << WORD_MAG,
  localparam int SET_W             = (UARC_SETS > 1) ? $clog2(UARC_SETS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [TOTAL_BUSES-1:0]                 receiver_sends,
  input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas,
  output logic [TOTAL_BUSES-1:0]                 receiver_send_acks,
  input  logic                                   enable_we,
  input  logic                                   selection_we,
  input  logic [SET_W-1:0]                       cfg_set,
  input  logic [WORD_WIDTH-1:0]                  cfg_value,
  input  logic                                   addr_we,
  input  logic [WORD_WIDTH-1:0]                  addr_bus,
  input  logic [PROGRAM_ADDR_WIDTH-1:0]          addr_value,
  input  logic                                   wait_req,
  input  logic                                   iret,
  output logic                                   halt,
  output logic                                   take,
  output logic [PROGRAM_ADDR_WIDTH-1:0]          take_pc,
  output logic [WORD_WIDTH-1:0]                  take_bus,
  output logic [WORD_WIDTH-1:0]                  data,
  output logic                                   interrupt_active
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                        state_r;
  state_t                        state_next_s;
  logic [TOTAL_BUSES-1:0]        enable_r;
  logic [TOTAL_BUSES-1:0]        selection_r;
  logic [PROGRAM_ADDR_WIDTH-1:0] addr_tab_r [TOTAL_BUSES];
  logic [WORD_WIDTH-1:0]         data_r;
  logic [TOTAL_BUSES-1:0]        acks_r;

  logic [TOTAL_BUSES-1:0]        mask_s;
  logic                          hit_s;
  logic [WORD_WIDTH-1:0]         chosen_s;
  logic [PROGRAM_ADDR_WIDTH-1:0] chosen_pc_s;
  logic [WORD_WIDTH-1:0]         chosen_data_s;
  logic [TOTAL_BUSES-1:0]        chosen_onehot_s;
  logic                          take_s;
  logic                          accept_s;
  logic                          halt_s;
  logic                          unused_cfg_s;

  // Only the low TOTAL_BUSES bits of a set map to real buses; the rest are dropped.
  assign unused_cfg_s = ^cfg_value;

  // Masking and lowest-index priority select; a bus being acknowledged is excluded.
  always_comb begin
    mask_s          = receiver_sends & (wait_req ? selection_r : enable_r) & ~acks_r;
    hit_s           = |mask_s;
    chosen_s        = '0;
    chosen_pc_s     = '0;
    chosen_data_s   = '0;
    chosen_onehot_s = '0;
    for (int i = TOTAL_BUSES - 1; i >= 0; i--) begin
      if (mask_s[i]) begin
        chosen_s           = WORD_WIDTH'(i);
        chosen_pc_s        = addr_tab_r[i];
        chosen_data_s      = receiver_datas[i];
        chosen_onehot_s    = '0;
        chosen_onehot_s[i] = 1'b1;
      end else begin
        chosen_s = chosen_s;
      end
    end
  end

  // FSM next state plus take/halt/accept decode.
  always_comb begin
    state_next_s = state_r;
    take_s       = 1'b0;
    halt_s       = wait_req & ~hit_s;
    accept_s     = hit_s & wait_req;
    case (state_r)
      ST_IDLE: begin
        if (hit_s && !wait_req) begin
          take_s       = 1'b1;
          accept_s     = 1'b1;
          state_next_s = ST_ACTIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (iret) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACTIVE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Enable/selection sets and handler address table; out-of-range targets are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r    <= '0;
      selection_r <= '0;
      for (int i = 0; i < TOTAL_BUSES; i++) begin
        addr_tab_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TOTAL_BUSES; i++) begin
        if (enable_we && (cfg_set == SET_W'(i / WORD_WIDTH))) begin
          enable_r[i] <= cfg_value[i % WORD_WIDTH];
        end
        if (selection_we && (cfg_set == SET_W'(i / WORD_WIDTH))) begin
          selection_r[i] <= cfg_value[i % WORD_WIDTH];
        end
        if (addr_we && (addr_bus == WORD_WIDTH'(i))) begin
          addr_tab_r[i] <= addr_value;
        end
      end
    end
  end

  // Payload capture and the one-cycle acknowledge pulse for the accepted bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= '0;
      acks_r <= '0;
    end else if (accept_s) begin
      data_r <= chosen_data_s;
      acks_r <= chosen_onehot_s;
    end else begin
      acks_r <= '0;
    end
  end

  assign receiver_send_acks = acks_r;
  assign data               = data_r;
  assign interrupt_active   = (state_r == ST_ACTIVE);
  assign take               = take_s;
  assign halt               = halt_s;
  assign take_bus           = chosen_s;
  assign take_pc            = hit_s ? chosen_pc_s : {PROGRAM_ADDR_WIDTH{1'b0}};

endmodule

// File: tb/tb_uarc_interrupt_ctrl.sv
// Directed-vector bench for uarc_interrupt_ctrl with default parameters (4 buses, 32-bit words).
module tb_uarc_interrupt_ctrl;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       receiver_sends;
  logic [3:0][31:0] receiver_datas;
  logic [3:0]       receiver_send_acks;
  logic             enable_we, selection_we;
  logic [0:0]       cfg_set;
  logic [31:0]      cfg_value;
  logic             addr_we;
  logic [31:0]      addr_bus;
  logic [7:0]       addr_value;
  logic             wait_req, iret;
  logic             halt, take;
  logic [7:0]       take_pc;
  logic [31:0]      take_bus;
  logic [31:0]      data;
  logic             interrupt_active;

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  uarc_interrupt_ctrl dut (
    .clk(clk), .reset(reset),
    .receiver_sends(receiver_sends), .receiver_datas(receiver_datas),
    .receiver_send_acks(receiver_send_acks),
    .enable_we(enable_we), .selection_we(selection_we), .cfg_set(cfg_set), .cfg_value(cfg_value),
    .addr_we(addr_we), .addr_bus(addr_bus), .addr_value(addr_value),
    .wait_req(wait_req), .iret(iret),
    .halt(halt), .take(take), .take_pc(take_pc), .take_bus(take_bus),
    .data(data), .interrupt_active(interrupt_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; receiver_sends = 4'b0000; receiver_datas = '0;
    enable_we = 1'b0; selection_we = 1'b0; cfg_set = 1'b0; cfg_value = 32'h0;
    addr_we = 1'b0; addr_bus = 32'h0; addr_value = 8'h00; wait_req = 1'b0; iret = 1'b0;
    tick(); tick();
    wait_req = 1'b1; #1;
    chk("rst_halt", {31'd0, halt}, 32'd1);
    chk("rst_take", {31'd0, take}, 32'd0);
    chk("rst_active", {31'd0, interrupt_active}, 32'd0);
    chk("rst_acks", {28'd0, receiver_send_acks}, 32'd0);
    chk("rst_data", data, 32'd0);
    wait_req = 1'b0; reset = 1'b0;

    // Enables 0110, addresses bus1=0x20, bus2=0x44, out-of-range bus 4 write
    enable_we = 1'b1; cfg_value = 32'h6; tick(); enable_we = 1'b0;
    addr_we = 1'b1; addr_bus = 32'd1; addr_value = 8'h20; tick();
    addr_bus = 32'd2; addr_value = 8'h44; tick();
    addr_bus = 32'd4; addr_value = 8'hFF; tick();
    addr_we = 1'b0;
    receiver_datas[0] = 32'hA0; receiver_datas[1] = 32'hA1; receiver_datas[2] = 32'hA2;

    receiver_sends = 4'b0111; #1;
    chk("t1_take", {31'd0, take}, 32'd1);
    chk("t1_pc", {24'd0, take_pc}, 32'h20);
    chk("t1_bus", take_bus, 32'd1);
    chk("t1_halt", {31'd0, halt}, 32'd0);
    tick();
    receiver_sends = 4'b0100; #1;
    chk("t1_ack", {28'd0, receiver_send_acks}, 32'b0010);
    chk("t1_active", {31'd0, interrupt_active}, 32'd1);
    chk("t1_data", data, 32'hA1);
    chk("nest_take0", {31'd0, take}, 32'd0);
    tick();
    chk("nest_take1", {31'd0, take}, 32'd0);
    chk("ack_one_cycle", {28'd0, receiver_send_acks}, 32'd0);
    tick();
    iret = 1'b1; #1;
    chk("iret_take", {31'd0, take}, 32'd0);
    tick();
    iret = 1'b0; #1;
    chk("post_iret_idle", {31'd0, interrupt_active}, 32'd0);
    chk("t2_take", {31'd0, take}, 32'd1);
    chk("t2_bus", take_bus, 32'd2);
    chk("t2_pc", {24'd0, take_pc}, 32'h44);
    tick();
    receiver_sends = 4'b0000; #1;
    chk("t2_ack", {28'd0, receiver_send_acks}, 32'b0100);
    chk("t2_data", data, 32'hA2);
    chk("nohit_pc", {24'd0, take_pc}, 32'd0);
    chk("nohit_bus", take_bus, 32'd0);
    iret = 1'b1; tick(); iret = 1'b0;

    // WAIT wake via selection set
    selection_we = 1'b1; cfg_value = 32'h8; tick(); selection_we = 1'b0;
    wait_req = 1'b1; #1;
    chk("w_halt", {31'd0, halt}, 32'd1);
    chk("w_take", {31'd0, take}, 32'd0);
    receiver_datas[3] = 32'hDEAD; receiver_sends = 4'b1000; #1;
    chk("wake_halt", {31'd0, halt}, 32'd0);
    chk("wake_take", {31'd0, take}, 32'd0);
    chk("wake_bus", take_bus, 32'd3);
    tick();
    receiver_sends = 4'b0000; #1;
    chk("wake_ack", {28'd0, receiver_send_acks}, 32'b1000);
    chk("wake_data", data, 32'hDEAD);
    chk("wake_state", {31'd0, interrupt_active}, 32'd0);
    wait_req = 1'b0; tick();

    // Simultaneous enable+selection write, then ack-cycle suppression during WAIT
    enable_we = 1'b1; selection_we = 1'b1; cfg_value = 32'h3; tick();
    enable_we = 1'b0; selection_we = 1'b0;
    wait_req = 1'b1; receiver_sends = 4'b0011; #1;
    chk("sup_bus0", take_bus, 32'd0);
    chk("sup_halt", {31'd0, halt}, 32'd0);
    tick();
    chk("sup_ack0", {28'd0, receiver_send_acks}, 32'b0001);
    chk("sup_next_bus", take_bus, 32'd1);
    chk("sup_data0", data, 32'hA0);
    tick();
    chk("sup_ack1", {28'd0, receiver_send_acks}, 32'b0010);
    chk("sup_bus_back0", take_bus, 32'd0);

    // Interrupt path with bus 0 (address never written, out-of-range write must not alias)
    wait_req = 1'b0; #1;
    chk("b0_take", {31'd0, take}, 32'd1);
    chk("b0_bus", take_bus, 32'd0);
    chk("b0_pc_unaliased", {24'd0, take_pc}, 32'd0);
    tick();
    iret = 1'b1; #1;
    chk("b0_ack", {28'd0, receiver_send_acks}, 32'b0001);
    chk("b0_take_active", {31'd0, take}, 32'd0);
    tick();
    chk("b0_retake", {31'd0, take}, 32'd1);
    chk("b0_retake_bus", take_bus, 32'd0);
    tick();
    receiver_sends = 4'b0000; #1;
    chk("b0_ack_onehot", {28'd0, receiver_send_acks}, 32'b0001);
    tick(); iret = 1'b0;

    // Enable write and send in the same cycle: take only from the next cycle
    enable_we = 1'b1; cfg_value = 32'h8; receiver_sends = 4'b1000; #1;
    chk("samecyc_take", {31'd0, take}, 32'd0);
    tick();
    enable_we = 1'b0; #1;
    chk("nextcyc_take", {31'd0, take}, 32'd1);
    chk("nextcyc_bus", take_bus, 32'd3);
    tick();
    reset = 1'b1; #1;
    chk("pre_rst_ack", {28'd0, receiver_send_acks}, 32'b1000);
    tick();
    reset = 1'b0; receiver_sends = 4'b0000; #1;
    chk("rst_mid_ack", {28'd0, receiver_send_acks}, 32'd0);
    chk("rst_mid_active", {31'd0, interrupt_active}, 32'd0);
    chk("rst_mid_data", data, 32'd0);
    receiver_sends = 4'b1111; #1;
    chk("rst_cleared_en", {31'd0, take}, 32'd0);
    wait_req = 1'b1; #1;
    chk("rst_cleared_sel", {31'd0, halt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/uarc_interrupt_ctrl.md
UARC_INTERRUPT_CTRL -- requirements
Module: uarc_interrupt_ctrl

Interface
REQ-001 SHALL have parameter WORD_MAG, default 5, log2 of word width; WORD_WIDTH = 1 << WORD_MAG.
REQ-002 SHALL have parameter UARC_SETS, default 1, number of WORD_WIDTH-bit enable/selection sets.
REQ-003 SHALL have parameter TOTAL_BUSES, default 4, receiver bus count, 1..UARC_SETS*WORD_WIDTH.
REQ-004 SHALL have parameter PROGRAM_ADDR_WIDTH, default 8, handler address width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 receiver_sends  input  TOTAL_BUSES  per-bus send request.
REQ-008 receiver_datas  input  TOTAL_BUSES x WORD_WIDTH  per-bus send payload.
REQ-009 receiver_send_acks  output  TOTAL_BUSES  per-bus acknowledge pulse.
REQ-010 enable_we, selection_we  input  1 each  write cfg_value into enable / selection set cfg_set.
REQ-011 cfg_set  input  max(1,clog2(UARC_SETS))  target set index.
REQ-012 cfg_value  input  WORD_WIDTH  set contents; bit b maps to bus cfg_set*WORD_WIDTH+b.
REQ-013 addr_we  input  1; addr_bus  input  WORD_WIDTH; addr_value  input  PROGRAM_ADDR_WIDTH  handler address table write.
REQ-014 wait_req  input  1  core executing WAIT.
REQ-015 iret  input  1  core returning from handler.
REQ-016 halt  output  1  core must stall PC.
REQ-017 take  output  1  interrupt taken this cycle; take_pc  output  PROGRAM_ADDR_WIDTH  handler address; take_bus  output  WORD_WIDTH  chosen bus index.
REQ-018 data  output  WORD_WIDTH  last accepted payload; interrupt_active  output  1  handler in progress.

Function
REQ-019 Mask SHALL be receiver_sends[i] AND (wait_req ? selection[i] : enable[i]) AND NOT receiver_send_acks[i], using registered config.
REQ-020 Chosen bus SHALL be the lowest-index masked bit; "hit" = any masked bit.
REQ-021 State machine SHALL have two states: IDLE (interrupt_active=0) and ACTIVE (interrupt_active=1).
REQ-022 IDLE, hit, wait_req=0: take=1 combinationally, take_pc=address[chosen], take_bus=chosen; next state ACTIVE.
REQ-023 Any state, hit, wait_req=1: wake; take=0, halt=0, state unchanged.
REQ-024 ACTIVE, wait_req=0: take=0 regardless of sends (no nesting).
REQ-025 halt SHALL equal wait_req AND NOT hit, in either state.
REQ-026 On any accept (take or wake), data SHALL load receiver_datas[chosen] at that edge; receiver_send_acks[chosen] SHALL be high exactly the following cycle, all other acks low.
REQ-027 A bus SHALL NOT be accepted in the cycle its ack is high (REQ-019 suppression); next-priority bus MAY be accepted that cycle.
REQ-028 ACTIVE with iret=1: next state IDLE; take SHALL be 0 in the iret cycle; interrupts eligible from the following cycle.
REQ-029 iret in IDLE SHALL be ignored.
REQ-030 Config and address writes SHALL take effect at the edge, visible in masking from the next cycle; addr_bus >= TOTAL_BUSES and set bits beyond TOTAL_BUSES SHALL be ignored.
REQ-031 Simultaneous enable_we and selection_we SHALL update both sets.
REQ-032 take_bus SHALL be 0 and take_pc SHALL be 0 when no hit.

Reset
REQ-033 reset SHALL clear enables, selections, address table, data, acks, and return to IDLE; outputs: take=0, halt=wait_req, interrupt_active=0, acks=0.
REQ-034 reset mid-handshake SHALL drop any pending ack; reset has priority over all inputs.

Verification
REQ-035 Enables=0b0110, addresses[1]=0x20, sends=0b0111 -> take=1, take_pc=0x20, take_bus=1; next cycle ack=0b0010, interrupt_active=1, data=datas[1].
REQ-036 ACTIVE, sends=0b0100 held -> take=0 until iret; iret cycle take=0; next cycle take=1, take_bus=2.
REQ-037 wait_req=1, selections=0b1000, sends=0 -> halt=1; sends=0b1000, data=0xDEAD -> halt=0, take=0, next cycle ack=0b1000, data=0xDEAD, state unchanged.
REQ-038 Enables=0b0011, sends=0b0011 held, state IDLE, iret each cycle after take -> bus 0 taken, its ack cycle suppresses bus 0 only; acks never two-hot.
REQ-039 Write enable set then sends same cycle -> no take that cycle; take next cycle. addr_bus=TOTAL_BUSES write -> table unchanged.
REQ-040 Reset asserted in ack cycle -> acks=0, interrupt_active=0, data=0 the next cycle.
